// File: rtl/param_hash_gen.sv
// Iterated rotate-add hash over a small host-loaded message memory.
// One READ/ABSORB pair per word, optional second pass, folded result in FINAL.
module param_hash_gen #(
  parameter int           W     = 32,
  parameter int           DEPTH = 16,
  parameter int           AW    = $clog2(DEPTH),
  parameter int           ROT   = 5,
  parameter logic [W-1:0] IV    = W'(32'h6A09E667),
  parameter logic [W-1:0] K     = W'(32'h9E3779B9)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   msgLen,
  input  logic          mode,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [W-1:0]  wrData,
  output logic          busy,
  output logic [W-1:0]  hashResult,
  output logic          dataOutValid,
  output logic          lenError
);

  typedef enum logic [1:0] {IDLE, READ, ABSORB, FINAL} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t         state, state_nx;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   rdata;
  logic [W-1:0]   h;
  logic [AW-1:0]  addr;
  logic [AW:0]    len;
  logic [AW+1:0]  idx, last;
  logic           len_ok;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
    return (x << ROT) | (x >> (W - ROT));
  endfunction

  assign len_ok = (msgLen != '0) && (msgLen <= DEPTH_L);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && len_ok) state_nx = READ;
      READ:    state_nx = ABSORB;
      ABSORB:  state_nx = (idx == last) ? FINAL : READ;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory is deliberately outside reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (wrEn && state == IDLE) mem[wrAddr] <= wrData;
    rdata <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h            <= IV;
      idx          <= '0;
      addr         <= '0;
      len          <= '0;
      last         <= '0;
      hashResult   <= '0;
      dataOutValid <= 1'b0;
      lenError     <= 1'b0;
    end else begin
      dataOutValid <= 1'b0;
      lenError     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (len_ok) begin
            len  <= msgLen;
            last <= (mode ? {msgLen, 1'b0} : {1'b0, msgLen}) - (AW+2)'(1);
            h    <= IV;
            idx  <= '0;
            addr <= '0;
          end else begin
            lenError <= 1'b1;
          end
        end
        ABSORB: begin
          h    <= rotl(h) + (rdata ^ K);
          idx  <= idx + (AW+2)'(1);
          // addr walks idx mod L without a divider
          addr <= ({1'b0, addr} == len - (AW+1)'(1)) ? '0 : addr + AW'(1);
        end
        FINAL: begin
          hashResult   <= h ^ (h >> (W/2));
          dataOutValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/param_hash_gen.md
PARAM_HASH_GEN -- requirements
Module: param_hash_gen

Interface
REQ-001 Parameter W, default 32, meaning message word and hash width in bits; W shall be even and at least 8.
REQ-002 Parameter DEPTH, default 16, meaning the number of words in the internal message memory; DEPTH shall be at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH), meaning the memory address width; it is derived and shall not be overridden.
REQ-004 Parameter ROT, default 5, meaning the left-rotate amount per absorb, in the range 0..W-1.
REQ-005 Parameter IV, default 32'h6A09E667 truncated or zero-extended to W, meaning the initial chaining value.
REQ-006 Parameter K, default 32'h9E3779B9 truncated or zero-extended to W, meaning the absorb constant.
REQ-007 Port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1 bit, meaning reset; synchronous and active-high.
REQ-009 Port start, input, 1 bit, meaning a request to hash; sampled only in IDLE.
REQ-010 Port msgLen, input, AW+1 bits, meaning the message length L in words; valid range 1..DEPTH.
REQ-011 Port mode, input, 1 bit, meaning pass count P: 0 gives one pass, 1 gives two passes over the message.
REQ-012 Port wrEn, input, 1 bit, meaning the host write strobe into the message memory.
REQ-013 Port wrAddr, input, AW bits, meaning the host write address.
REQ-014 Port wrData, input, W bits, meaning the host write data.
REQ-015 Port busy, output, 1 bit, meaning a hash is in progress.
REQ-016 Port hashResult, output, W bits, meaning the last completed hash, held until overwritten.
REQ-017 Port dataOutValid, output, 1 bit, meaning a one-cycle pulse marking that hashResult has been updated.
REQ-018 Port lenError, output, 1 bit, meaning a one-cycle pulse marking that a start was rejected for an invalid length.

Function
REQ-019 The block shall contain an internal DEPTH x W memory with a synchronous write and a 1-cycle synchronous read.
REQ-020 The FSM shall have the states IDLE, READ, ABSORB and FINAL.
REQ-021 In IDLE, wrEn=1 shall write wrData to mem[wrAddr] at the clock edge; wrEn shall be ignored in all other states.
REQ-022 In IDLE, start=1 with a valid msgLen shall latch L=msgLen and P=mode+1, set H=IV and idx=0, and go to READ.
REQ-023 In IDLE, start=1 with msgLen=0 or msgLen>DEPTH shall stay in IDLE, pulse lenError the next cycle, and leave hashResult and busy unchanged.
REQ-024 READ shall present address idx mod L to the memory and go to ABSORB.
REQ-025 ABSORB shall compute H = rotl(H, ROT) + (rdata XOR K), mod 2^W, and increment idx.
REQ-026 ABSORB shall go to FINAL when idx reaches L*P-1 before the increment; otherwise it shall go to READ.
REQ-027 FINAL shall load hashResult = H XOR (H >> W/2), set dataOutValid=1 for exactly one cycle, and go to IDLE.
REQ-028 busy shall be 1 in READ, ABSORB and FINAL, and 0 in IDLE.
REQ-029 Latency: dataOutValid shall be high exactly 2*L*P+2 cycles after the cycle in which start was accepted.
REQ-030 start while busy shall be ignored; msgLen and mode changes while busy shall have no effect.
REQ-031 start and dataOutValid in the same cycle shall be accepted, because the FSM is in IDLE.
REQ-032 A simultaneous wrEn and start in IDLE shall perform the write, and hashing shall read the newly written value.
REQ-033 During pass 2 the address shall wrap from L-1 back to 0.

Reset
REQ-034 rst=1 at a clock edge shall force IDLE, busy=0, dataOutValid=0, lenError=0, hashResult=0, idx=0 and H=IV.
REQ-035 Reset mid-hash shall abort the hash with no dataOutValid pulse.
REQ-036 Reset shall not clear the memory contents.
REQ-037 A start during rst=1 shall be ignored.

Verification
REQ-038 With IV=0, K=0, ROT=5, the bench shall write mem[0]=1, then start with msgLen=1 and mode=0 -> dataOutValid 4 cycles later, hashResult=0x00000001.
REQ-039 With the same parameters, mem={1,2}, msgLen=2, mode=0 -> dataOutValid after 6 cycles, hashResult=0x00000022.
REQ-040 With the same setup and mode=1 -> dataOutValid after 10 cycles, hashResult=0x00008822, and busy high for 9 cycles.
REQ-041 start with msgLen=0, and separately with msgLen=DEPTH+1 -> a lenError pulse the next cycle, busy=0, hashResult unchanged.
REQ-042 rst pulsed 3 cycles into the REQ-040 run -> busy=0 and hashResult=0 with no dataOutValid; rerunning without rewriting memory -> hashResult=0x00008822.
REQ-043 wrEn to mem[0]=7 and start pulses during busy -> both ignored and the result equals the REQ-039 value; wrEn mem[0]=7 together with start in IDLE (msgLen=1) -> hashResult=0x00000007.
